// File: rtl/fp_add_sub_normalize_shifter.sv
// fp_add_sub_normalize_shifter
//   Left-normalizes the raw post-add mantissa of the FP add/sub datapath using
//   the leading-one index from the priority encoder, and lowers the exponent
//   by the applied shift. The shift is clamped by the exponent so the result
//   becomes subnormal instead of the exponent wrapping.
//   Two-stage valid/ready pipeline: stage 1 computes the shift and applies the
//   coarse (multiple-of-4) part; stage 2 applies the fine 0..3 part.
// Ports
//   clock, aclr              rising-edge clock, async active-high reset
//   in_valid/in_ready        upstream handshake
//   in_mant/in_exp           unnormalized mantissa and its exponent
//   in_pos/in_zero           encoder MSB-one index / all-zero flag
//   out_valid/out_ready      downstream handshake
//   out_mant/out_exp         normalized mantissa / adjusted exponent
//   out_zero/out_denorm      exact-zero result / shift clamped by exponent
module fp_add_sub_normalize_shifter #(
  parameter int unsigned WIDTH     = 28,
  parameter int unsigned WIDTHAD   = 5,
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mant,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [WIDTHAD-1:0]   in_pos,
  input  logic                 in_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_mant,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_denorm
);

  // Common width for comparing shift against exponent.
  localparam int unsigned CW = (WIDTHAD > EXP_WIDTH) ? WIDTHAD : EXP_WIDTH;

  // Stage 1 combinational shift computation
  logic [WIDTHAD-1:0]   w_pos;
  logic [WIDTHAD-1:0]   w_shift;
  logic [CW-1:0]        w_shift_x;
  logic [CW-1:0]        w_exp_x;
  logic [CW-1:0]        w_eff_x;
  logic [WIDTHAD-1:0]   w_shift_eff;
  logic [WIDTHAD-1:0]   w_coarse;
  logic [1:0]           w_fine;
  logic                 w_denorm;
  logic [EXP_WIDTH-1:0] w_exp_adj;
  logic [WIDTH-1:0]     w_mant_coarse;
  logic                 w_s2_ready;

  // Pipeline registers
  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_mant;
  logic [EXP_WIDTH-1:0] r_s1_exp;
  logic [1:0]           r_s1_fine;
  logic                 r_s1_zero;
  logic                 r_s1_denorm;

  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_s2_mant;
  logic [EXP_WIDTH-1:0] r_s2_exp;
  logic                 r_s2_zero;
  logic                 r_s2_denorm;

  always_comb begin
    // Out-of-range index (non-power-of-2 WIDTH) behaves as already normalized.
    w_pos = in_pos;
    if (32'(in_pos) > WIDTH - 1) begin
      w_pos = WIDTHAD'(WIDTH - 1);
    end
    w_shift       = WIDTHAD'(WIDTH - 1) - w_pos;
    w_shift_x     = CW'(w_shift);
    w_exp_x       = CW'(in_exp);
    w_denorm      = (w_shift_x > w_exp_x);
    w_eff_x       = w_denorm ? w_exp_x : w_shift_x;
    // Both truncations are lossless: w_eff_x <= w_shift and w_eff_x <= in_exp.
    w_shift_eff   = WIDTHAD'(w_eff_x);
    w_exp_adj     = in_exp - EXP_WIDTH'(w_eff_x);
    w_coarse      = w_shift_eff & ~WIDTHAD'(3);
    w_fine        = 2'(w_shift_eff);
    w_mant_coarse = in_mant << w_coarse;
  end

  // s2 can take a beat when empty or when its beat leaves this cycle.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_s1_valid  <= 1'b0;
      r_s1_mant   <= '0;
      r_s1_exp    <= '0;
      r_s1_fine   <= '0;
      r_s1_zero   <= 1'b0;
      r_s1_denorm <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        if (in_zero) begin
          r_s1_mant   <= '0;
          r_s1_exp    <= '0;
          r_s1_fine   <= '0;
          r_s1_zero   <= 1'b1;
          r_s1_denorm <= 1'b0;
        end else begin
          r_s1_mant   <= w_mant_coarse;
          r_s1_exp    <= w_exp_adj;
          r_s1_fine   <= w_fine;
          r_s1_zero   <= 1'b0;
          r_s1_denorm <= w_denorm;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_s2_valid  <= 1'b0;
      r_s2_mant   <= '0;
      r_s2_exp    <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_denorm <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      // Data only updates on a real beat so outputs hold while idle.
      if (r_s1_valid) begin
        r_s2_mant   <= r_s1_mant << r_s1_fine;
        r_s2_exp    <= r_s1_exp;
        r_s2_zero   <= r_s1_zero;
        r_s2_denorm <= r_s1_denorm;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_mant   = r_s2_mant;
  assign out_exp    = r_s2_exp;
  assign out_zero   = r_s2_zero;
  assign out_denorm = r_s2_denorm;

endmodule

// File: tb/tb_fp_add_sub_normalize_shifter.sv
// tb_fp_add_sub_normalize_shifter
//   Directed-vector bench for fp_add_sub_normalize_shifter at WIDTH=8,
//   WIDTHAD=3, EXP_WIDTH=8. Expected beats are hand-computed and queued on
//   acceptance; a monitor compares each consumed output beat in order.
module tb_fp_add_sub_normalize_shifter;

  logic       clock;
  logic       aclr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mant;
  logic [7:0] in_exp;
  logic [2:0] in_pos;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [7:0] out_exp;
  logic       out_zero;
  logic       out_denorm;

  fp_add_sub_normalize_shifter #(
    .WIDTH     (8),
    .WIDTHAD   (3),
    .EXP_WIDTH (8)
  ) u_dut (
    .clock      (clock),
    .aclr       (aclr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .in_pos     (in_pos),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [31:0] exp_q[$];
  int unsigned cyc      = 0;
  int unsigned n_stall  = 0;
  logic        track    = 1'b0;
  int unsigned trk_n    = 0;
  int unsigned trk_last = 0;
  int unsigned gaps     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] m, input logic [7:0] e,
                                     input logic z, input logic d);
    return {14'b0, m, e, z, d};
  endfunction

  function automatic logic [31:0] pk_out();
    return {14'b0, out_mant, out_exp, out_zero, out_denorm};
  endfunction

  always @(posedge clock) cyc++;

  // Output monitor: a beat seen valid&ready at the negedge is consumed at the next edge.
  always @(negedge clock) begin
    if (!aclr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        check_eq("out_beat", pk_out(), exp_q.pop_front());
      end
      if (track) begin
        if (trk_n > 0 && cyc != trk_last + 1) gaps++;
        trk_last = cyc;
        trk_n++;
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic [2:0] p, input logic [7:0] e,
                      input logic z, input logic [31:0] want);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_mant  = m;
    in_pos   = p;
    in_exp   = e;
    in_zero  = z;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(want);
      end else begin
        n_stall++;
      end
      @(posedge clock);
      #1;
    end
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0]  b_mant[3];
  logic [2:0]  b_pos[3];
  logic [7:0]  b_exp[3];
  logic [31:0] b_want[3];

  initial begin
    int unsigned idx;
    int unsigned acc_cnt;
    int unsigned unstable;
    logic [7:0]  snap;
    logic        snap_ok;

    aclr      = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_pos    = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", pk_out(), pk(8'h00, 8'd0, 1'b0, 1'b0));
    @(posedge clock);
    @(posedge clock);
    #1;
    aclr = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // 1: basic normalize and two-cycle latency
    send(8'h13, 3'd4, 8'd20, 1'b0, pk(8'h98, 8'd17, 1'b0, 1'b0));
    @(negedge clock);
    check_eq("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    check_eq("lat_c2_valid", 32'(out_valid), 32'd1);
    drain();

    // 2: shift clamped by exponent
    send(8'h01, 3'd0, 8'd3, 1'b0, pk(8'h08, 8'd0, 1'b0, 1'b1));
    // 3: zero override, then already-normalized passthrough
    send(8'h00, 3'd3, 8'd55, 1'b1, pk(8'h00, 8'd0, 1'b1, 1'b0));
    send(8'h80, 3'd7, 8'd9, 1'b0, pk(8'h80, 8'd9, 1'b0, 1'b0));
    // Coarse+fine shift of 5, full shift of 7, exp=0 no shift, shift equal to exp
    send(8'h05, 3'd2, 8'd100, 1'b0, pk(8'hA0, 8'd95, 1'b0, 1'b0));
    send(8'h01, 3'd0, 8'd50, 1'b0, pk(8'h80, 8'd43, 1'b0, 1'b0));
    send(8'h40, 3'd6, 8'd0, 1'b0, pk(8'h40, 8'd0, 1'b0, 1'b1));
    send(8'h03, 3'd1, 8'd6, 1'b0, pk(8'hC0, 8'd0, 1'b0, 1'b0));
    send(8'h2B, 3'd5, 8'd1, 1'b0, pk(8'h56, 8'd0, 1'b0, 1'b1));
    drain();

    // 4: 16 back-to-back beats
    gaps    = 0;
    trk_n   = 0;
    n_stall = 0;
    track   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        send(8'h80 | 8'(i), 3'd7, 8'(10 + i), 1'b0, pk(8'h80 | 8'(i), 8'(10 + i), 1'b0, 1'b0));
      end else begin
        send(8'h01, 3'd0, 8'(10 + i), 1'b0, pk(8'h80, 8'(3 + i), 1'b0, 1'b0));
      end
    end
    drain();
    track = 1'b0;
    check_eq("b2b_beats", 32'(trk_n), 32'd16);
    check_eq("b2b_gaps", 32'(gaps), 32'd0);
    check_eq("b2b_stalls", 32'(n_stall), 32'd0);

    // 5: downstream stall with continuous input
    b_mant[0] = 8'h13; b_pos[0] = 3'd4; b_exp[0] = 8'd20; b_want[0] = pk(8'h98, 8'd17, 1'b0, 1'b0);
    b_mant[1] = 8'h01; b_pos[1] = 3'd0; b_exp[1] = 8'd3;  b_want[1] = pk(8'h08, 8'd0, 1'b0, 1'b1);
    b_mant[2] = 8'h05; b_pos[2] = 3'd2; b_exp[2] = 8'd100; b_want[2] = pk(8'hA0, 8'd95, 1'b0, 1'b0);
    out_ready = 1'b0;
    idx       = 0;
    acc_cnt   = 0;
    unstable  = 0;
    snap      = '0;
    snap_ok   = 1'b0;
    in_valid  = 1'b1;
    in_zero   = 1'b0;
    in_mant   = b_mant[0];
    in_pos    = b_pos[0];
    in_exp    = b_exp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (in_ready) begin
        if (idx < 3) exp_q.push_back(b_want[idx]);
        idx++;
        acc_cnt++;
      end
      if (out_valid) begin
        if (!snap_ok) begin
          snap    = out_mant;
          snap_ok = 1'b1;
        end else if (out_mant != snap) begin
          unstable++;
        end
      end
      @(posedge clock);
      #1;
      if (idx < 3) begin
        in_mant = b_mant[idx];
        in_pos  = b_pos[idx];
        in_exp  = b_exp[idx];
      end
    end
    check_eq("stall_accepted", 32'(acc_cnt), 32'd2);
    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
    check_eq("stall_out_head", pk_out(), pk(8'h98, 8'd17, 1'b0, 1'b0));
    check_eq("stall_stable", 32'(unstable), 32'd0);
    out_ready = 1'b1;
    if (idx < 3) send(b_mant[idx], b_pos[idx], b_exp[idx], 1'b0, b_want[idx]);
    drain();

    // 6: reset with two beats in flight
    send(8'h13, 3'd4, 8'd20, 1'b0, pk(8'h98, 8'd17, 1'b0, 1'b0));
    send(8'h05, 3'd2, 8'd100, 1'b0, pk(8'hA0, 8'd95, 1'b0, 1'b0));
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    aclr = 1'b1;
    #1;
    exp_q.delete();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", pk_out(), pk(8'h00, 8'd0, 1'b0, 1'b0));
    @(posedge clock);
    @(posedge clock);
    #1;
    aclr = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check_eq("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clock);
    #1;
    send(8'h03, 3'd1, 8'd6, 1'b0, pk(8'hC0, 8'd0, 1'b0, 1'b0));
    drain();
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
